// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 13-bit LFSR generator stream: self-synchronises
// to the incoming bits, then flywheels its own register and counts disagreements.
`timescale 1ns/1ps

module lfsr_stream_checker #(
   parameter int LOCK_MATCHES = 26,
   parameter int LOSS_ERRS    = 8,
   parameter int LOSS_WINDOW  = 64,
   parameter int CNT_W        = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             clear_errs,
   output logic             locked,
   output logic             err_pulse,
   output logic             lock_lost,
   output logic [CNT_W-1:0] err_count
);

   localparam int MW = $clog2(LOCK_MATCHES + 1);
   localparam int WW = $clog2(LOSS_WINDOW + 1);
   localparam int EW = $clog2(LOSS_ERRS + 1);

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t          state;
   logic [12:0]     sr;
   logic [3:0]      fill_cnt;
   logic [MW-1:0]   match_cnt;
   logic [WW-1:0]   win_cnt;
   logic [EW-1:0]   win_errs;

   logic            pred;
   logic            err;
   logic [12:0]     sr_rx;
   logic [12:0]     sr_fly;
   logic [EW-1:0]   win_errs_nxt;
   logic            fill_done;
   logic            match_done;
   logic            win_last;
   logic            loss;

   // Prediction, candidate shift values and the window bookkeeping decisions.
   always_comb begin
      pred         = sr[12] ^ sr[3] ^ sr[2] ^ sr[0];
      err          = bit_in ^ pred;
      sr_rx        = {sr[11:0], bit_in};
      sr_fly       = {sr[11:0], pred};
      win_errs_nxt = err ? (win_errs + EW'(1)) : win_errs;
      fill_done    = (fill_cnt == 4'd12);
      match_done   = (match_cnt == MW'(LOCK_MATCHES - 1));
      win_last     = (win_cnt == WW'(LOSS_WINDOW - 1));
      loss         = err && (win_errs_nxt == EW'(LOSS_ERRS));
   end

   // Acquisition / lock state machine with registered status outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= FILL;
         sr        <= '0;
         fill_cnt  <= '0;
         match_cnt <= '0;
         win_cnt   <= '0;
         win_errs  <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         lock_lost <= 1'b0;
         err_count <= '0;
      end else begin
         err_pulse <= 1'b0;
         lock_lost <= 1'b0;

         // A clear request always beats a coincident error increment.
         if (clear_errs)
            err_count <= '0;
         else if (state == LOCKED && bit_valid && err && err_count != '1)
            err_count <= err_count + CNT_W'(1);

         case (state)
            FILL: begin
               if (bit_valid) begin
                  sr <= sr_rx;
                  if (fill_done) begin
                     fill_cnt <= '0;
                     if (sr_rx != 13'd0) begin
                        state     <= VERIFY;
                        match_cnt <= '0;
                     end
                  end else begin
                     fill_cnt <= fill_cnt + 4'd1;
                  end
               end
            end

            VERIFY: begin
               if (bit_valid) begin
                  if (!err) begin
                     sr <= sr_rx;
                     if (match_done) begin
                        state     <= LOCKED;
                        locked    <= 1'b1;
                        match_cnt <= '0;
                        win_cnt   <= '0;
                        win_errs  <= '0;
                     end else begin
                        match_cnt <= match_cnt + MW'(1);
                     end
                  end else begin
                     state    <= FILL;
                     fill_cnt <= '0;
                  end
               end
            end

            LOCKED: begin
               if (bit_valid) begin
                  // Flywheel on the prediction so a bad bit cannot corrupt the register.
                  sr        <= sr_fly;
                  err_pulse <= err;
                  if (loss) begin
                     state     <= FILL;
                     fill_cnt  <= '0;
                     locked    <= 1'b0;
                     lock_lost <= 1'b1;
                     win_cnt   <= '0;
                     win_errs  <= '0;
                  end else if (win_last) begin
                     win_cnt  <= '0;
                     win_errs <= '0;
                  end else begin
                     win_cnt  <= win_cnt + WW'(1);
                     win_errs <= win_errs_nxt;
                  end
               end
            end

            default: begin
               state    <= FILL;
               fill_cnt <= '0;
               locked   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Scoreboard bench for lfsr_stream_checker: directed stream scenarios push the
// expected per-cycle outputs, a monitor pops and compares after each edge.
`timescale 1ns/1ps

module tb_lfsr_stream_checker;

   logic        clock;
   logic        reset;
   logic        bit_in;
   logic        bit_valid;
   logic        clear_errs;
   logic        locked;
   logic        err_pulse;
   logic        lock_lost;
   logic [15:0] err_count;

   typedef struct {
      logic        locked;
      logic        errp;
      logic        lost;
      logic [15:0] cnt;
      int          phase;
   } exp_t;

   exp_t        sbq[$];
   int          total;
   int          bad;
   int          phase;
   logic [12:0] gen_sr;

   lfsr_stream_checker #(
      .LOCK_MATCHES(26),
      .LOSS_ERRS(8),
      .LOSS_WINDOW(64),
      .CNT_W(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bit_in(bit_in),
      .bit_valid(bit_valid),
      .clear_errs(clear_errs),
      .locked(locked),
      .err_pulse(err_pulse),
      .lock_lost(lock_lost),
      .err_count(err_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference generator: emits its feedback bit and shifts it in as the new LSB.
   task automatic genNext(output logic b);
      b      = gen_sr[12] ^ gen_sr[3] ^ gen_sr[2] ^ gen_sr[0];
      gen_sr = {gen_sr[11:0], b};
   endtask

   task automatic applyStimulus(input logic b, input logic v, input logic c, input logic r,
                                input logic el, input logic ep, input logic ell,
                                input logic [15:0] ec);
      exp_t e;
      @(negedge clock);
      bit_in     = b;
      bit_valid  = v;
      clear_errs = c;
      reset      = r;
      e.locked   = el;
      e.errp     = ep;
      e.lost     = ell;
      e.cnt      = ec;
      e.phase    = phase;
      sbq.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      total++;
      if (locked !== e.locked) begin
         bad++;
         $display("[TB] FAIL locked phase=%0d got=%b want=%b", e.phase, locked, e.locked);
      end
      total++;
      if (err_pulse !== e.errp) begin
         bad++;
         $display("[TB] FAIL err_pulse phase=%0d got=%b want=%b", e.phase, err_pulse, e.errp);
      end
      total++;
      if (lock_lost !== e.lost) begin
         bad++;
         $display("[TB] FAIL lock_lost phase=%0d got=%b want=%b", e.phase, lock_lost, e.lost);
      end
      total++;
      if (err_count !== e.cnt) begin
         bad++;
         $display("[TB] FAIL err_count phase=%0d got=%0d want=%0d", e.phase, err_count, e.cnt);
      end
   endtask

   // Monitor: outputs settle after the rising edge, compare away from both edges.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #2;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired queue=%0d", sbq.size());
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic b;
      int   vc;
      int   guard;
      total      = 0;
      bad        = 0;
      phase      = 0;
      gen_sr     = 13'h000F;
      reset      = 1'b1;
      bit_in     = 1'b0;
      bit_valid  = 1'b0;
      clear_errs = 1'b0;

      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 0);

      // Clean acquisition, lock after the 39th bit, then a long clean run.
      phase = 1;
      for (int k = 1; k <= 39; k++) begin
         genNext(b);
         applyStimulus(b, 1, 0, 0, (k == 39), 0, 0, 0);
      end
      for (int k = 0; k < 1000; k++) begin
         genNext(b);
         applyStimulus(b, 1, 0, 0, 1, 0, 0, 0);
      end

      // Single inverted bit while locked, then flywheel stays clean.
      phase = 2;
      genNext(b);
      applyStimulus(~b, 1, 0, 0, 1, 1, 0, 1);
      for (int k = 0; k < 100; k++) begin
         genNext(b);
         applyStimulus(b, 1, 0, 0, 1, 0, 0, 1);
      end
      applyStimulus(1, 0, 1, 0, 1, 0, 0, 0);

      // Eight errors inside one window force loss, then a clean relock.
      phase = 3;
      for (int e = 1; e <= 8; e++) begin
         genNext(b);
         applyStimulus(~b, 1, 0, 0, (e < 8), 1, (e == 8), 16'(e));
      end
      for (int k = 1; k <= 39; k++) begin
         genNext(b);
         applyStimulus(b, 1, 0, 0, (k == 39), 0, 0, 8);
      end
      for (int k = 0; k < 5; k++) begin
         genNext(b);
         applyStimulus(b, 1, 0, 0, 1, 0, 0, 8);
      end

      // Reset while locked, then corrupt the 20th acquisition bit.
      phase = 4;
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 59; k++) begin
         genNext(b);
         applyStimulus((k == 20) ? ~b : b, 1, 0, 0, (k == 59), 0, 0, 0);
      end

      // Clear coinciding with an error.
      phase = 5;
      for (int k = 0; k < 5; k++) begin
         genNext(b);
         applyStimulus(b, 1, 0, 0, 1, 0, 0, 0);
      end
      genNext(b);
      applyStimulus(~b, 1, 0, 0, 1, 1, 0, 1);
      for (int k = 0; k < 5; k++) begin
         genNext(b);
         applyStimulus(b, 1, 0, 0, 1, 0, 0, 1);
      end
      genNext(b);
      applyStimulus(~b, 1, 1, 0, 1, 1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         genNext(b);
         applyStimulus(b, 1, 0, 0, 1, 0, 0, 0);
      end

      // All-zero input never locks.
      phase = 6;
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 200; k++)
         applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

      // Clean stream with random valid gaps locks on the 39th valid bit.
      phase = 7;
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
      vc    = 0;
      guard = 0;
      while (vc < 50 && guard < 1000) begin
         guard++;
         if ($urandom_range(0, 2) != 0) begin
            genNext(b);
            vc++;
            applyStimulus(b, 1, 0, 0, (vc >= 39), 0, 0, 0);
         end else begin
            applyStimulus(1'($urandom_range(0, 1)), 0, 0, 0, (vc >= 39), 0, 0, 0);
         end
      end

      repeat (2) @(posedge clock);
      #3;
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain got=%0d want=0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
